// File: rtl/pulse_pair_meter_pkg.sv
// Shared definitions for pulse_pair_meter: measurement FSM states and result flag bit positions.
package pulse_pair_meter_pkg;

    typedef enum logic {
        StIdle,
        StMeasure
    } state_e;

    localparam int unsigned FlagOverflow = 0;
    localparam int unsigned FlagYMissing = 1;
    localparam int unsigned FlagLost     = 2;

endpackage

// File: rtl/pulse_pair_meter_edge_detect.sv
// Registered previous-sample edge detector for one pulse input.
// PULSE_METER_SYNC_EN adds a 2-flop synchronizer ahead of the edge detector.
module pulse_pair_meter_edge_detect (
    input  logic sysclk,
    input  logic reset,
    input  logic pulse,
    output logic rise,
    output logic fall
);

    logic cur;
    logic prev_q;

`ifdef PULSE_METER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pulse};
        end
    end

    assign cur = sync_q[1];
`else
    assign cur = pulse;
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= cur;
        end
    end

    assign rise = cur & ~prev_q;
    assign fall = ~cur & prev_q;

endmodule

// File: rtl/pulse_pair_meter.sv
// Measures X period, X high time and X-rise to Y-rise delay per X cycle; results on valid/ready.
// PULSE_METER_SYNC_EN (in the edge detectors) synchronizes pulse_x/pulse_y for unrelated clocks.
module pulse_pair_meter
    import pulse_pair_meter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             pulse_x,
    input  logic             pulse_y,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_x,
    output logic [CNT_W-1:0] high_x,
    output logic [CNT_W-1:0] delay_xy,
    output logic [2:0]       flags
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic x_rise, x_fall, y_rise, y_fall;
    logic unused_y_fall;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q, high_q, delay_q;
    logic             seen_fall_q, seen_y_q, lost_q;

    logic             overflow, emit, y_hit;
    logic [CNT_W-1:0] res_high, res_delay;
    logic [2:0]       res_flags;

    pulse_pair_meter_edge_detect u_edge_x (
        .sysclk (sysclk),
        .reset  (reset),
        .pulse  (pulse_x),
        .rise   (x_rise),
        .fall   (x_fall)
    );

    pulse_pair_meter_edge_detect u_edge_y (
        .sysclk (sysclk),
        .reset  (reset),
        .pulse  (pulse_y),
        .rise   (y_rise),
        .fall   (y_fall)
    );

    assign unused_y_fall = y_fall;

    // An X fall or first Y rise on the overflow cycle still counts toward that result.
    always_comb begin
        overflow  = (state_q == StMeasure) && !x_rise && (cnt_q == CntMax);
        emit      = (state_q == StMeasure) && (x_rise || overflow);
        y_hit     = seen_y_q || (overflow && y_rise);
        res_high  = seen_fall_q ? high_q : cnt_q;
        res_delay = seen_y_q ? delay_q : (y_hit ? cnt_q : CntMax);
        res_flags               = '0;
        res_flags[FlagOverflow] = overflow;
        res_flags[FlagYMissing] = !y_hit;
        res_flags[FlagLost]     = lost_q;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            high_q      <= '0;
            delay_q     <= '0;
            seen_fall_q <= 1'b0;
            seen_y_q    <= 1'b0;
            lost_q      <= 1'b0;
            meas_valid  <= 1'b0;
            period_x    <= '0;
            high_x      <= '0;
            delay_xy    <= '0;
            flags       <= '0;
        end else begin
            if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end
            // A result arriving while the previous one is still unconsumed is dropped.
            if (emit) begin
                if (!meas_valid || meas_ready) begin
                    meas_valid <= 1'b1;
                    period_x   <= cnt_q;
                    high_x     <= res_high;
                    delay_xy   <= res_delay;
                    flags      <= res_flags;
                    lost_q     <= 1'b0;
                end else begin
                    lost_q <= 1'b1;
                end
            end

            if (x_rise) begin
                state_q     <= StMeasure;
                cnt_q       <= CntOne;
                seen_fall_q <= 1'b0;
                seen_y_q    <= y_rise;
                delay_q     <= '0;
            end else if (state_q == StMeasure) begin
                if (overflow) begin
                    state_q <= StIdle;
                end else begin
                    cnt_q <= cnt_q + CntOne;
                    if (x_fall) begin
                        high_q      <= cnt_q;
                        seen_fall_q <= 1'b1;
                    end
                    if (y_rise && !seen_y_q) begin
                        delay_q  <= cnt_q;
                        seen_y_q <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_pair_meter.sv
// Self-checking bench for pulse_pair_meter: timestamp-based reference model plus directed literals.
module tb_pulse_pair_meter;

    localparam int MAXC = 65535;

    logic        clk;
    logic        rst;
    logic        x, y, rdy;
    logic        valid;
    logic [15:0] per, hi, dly;
    logic [2:0]  flg;
    logic        x4, y4, rdy4;
    logic        valid4;
    logic [3:0]  per4, hi4, dly4;
    logic [2:0]  flg4;

    int n_checks = 0;
    int n_err    = 0;

    pulse_pair_meter #(.CNT_W(16)) dut (
        .sysclk     (clk),
        .reset      (rst),
        .pulse_x    (x),
        .pulse_y    (y),
        .meas_ready (rdy),
        .meas_valid (valid),
        .period_x   (per),
        .high_x     (hi),
        .delay_xy   (dly),
        .flags      (flg)
    );

    pulse_pair_meter #(.CNT_W(4)) dut4 (
        .sysclk     (clk),
        .reset      (rst),
        .pulse_x    (x4),
        .pulse_y    (y4),
        .meas_ready (rdy4),
        .meas_valid (valid4),
        .period_x   (per4),
        .high_x     (hi4),
        .delay_xy   (dly4),
        .flags      (flg4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: timestamps of window open, X fall and first Y rise, in sampled cycles.
    bit          started = 0;
    int          n = 0;
    bit          mx_prev = 0, my_prev = 0, m_open = 0, m_lost = 0;
    int          t_open = 0, t_fall = -1, t_y = -1;
    bit          e_valid = 0;
    int          e_per = 0, e_hi = 0, e_dly = 0;
    logic [2:0]  e_flg = 3'b000;

    always @(posedge clk) begin
        bit xr, xf, yr, have, r_ovf, r_ymiss;
        int r_per, r_hi, r_dly;
        n++;
        have = 0; r_ovf = 0; r_ymiss = 0; r_per = 0; r_hi = 0; r_dly = 0;
        if (rst) begin
            m_open = 0; m_lost = 0; t_fall = -1; t_y = -1;
            e_valid = 0; e_per = 0; e_hi = 0; e_dly = 0; e_flg = 3'b000;
        end else begin
            xr = x & !mx_prev;
            xf = !x & mx_prev;
            yr = y & !my_prev;
            if (m_open) begin
                if (xr) begin
                    have = 1;
                    r_per = n - t_open;
                end else begin
                    if (xf && t_fall < 0) t_fall = n;
                    if (yr && t_y < 0) t_y = n;
                    if (n - t_open == MAXC) begin
                        have = 1; r_ovf = 1; r_per = MAXC;
                    end
                end
                if (have) begin
                    r_hi    = (t_fall >= 0) ? t_fall - t_open : r_per;
                    r_ymiss = (t_y < 0);
                    r_dly   = r_ymiss ? MAXC : t_y - t_open;
                end
            end
            if (xr) begin
                m_open = 1; t_open = n; t_fall = -1; t_y = yr ? n : -1;
            end else if (r_ovf) begin
                m_open = 0;
            end
            if (have) begin
                if (!e_valid || rdy) begin
                    e_valid = 1; e_per = r_per; e_hi = r_hi; e_dly = r_dly;
                    e_flg = {m_lost, r_ymiss, r_ovf};
                    m_lost = 0;
                end else begin
                    m_lost = 1;
                end
            end else if (e_valid && rdy) begin
                e_valid = 0;
            end
        end
        mx_prev = rst ? 1'b0 : x;
        my_prev = rst ? 1'b0 : y;
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            n_checks++;
            if ({valid, per, hi, dly, flg} !== {e_valid, e_per[15:0], e_hi[15:0], e_dly[15:0], e_flg})
            begin
                n_err++;
                $display("FAIL model cycle %0d: got v=%0b p=%0d h=%0d d=%0d f=%b, expected v=%0b p=%0d h=%0d d=%0d f=%b",
                         n, valid, per, hi, dly, flg, e_valid, e_per, e_hi, e_dly, e_flg);
            end
        end
    end

    // Every accepted transfer, in order.
    logic [50:0] got[$];
    always @(negedge clk) begin
        if (started && !rst && valid && rdy) got.push_back({per, hi, dly, flg});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_period(input int pd, input int hd, input int yd, input int rdy_idx,
                              input logic rdy_val);
        for (int i = 0; i < pd; i++) begin
            x = (i < hd);
            y = (yd >= 0) && (i >= yd) && (i < yd + 2);
            if (i == rdy_idx) rdy = rdy_val;
            step();
        end
    endtask

    function automatic logic [50:0] mk(input int p, input int h, input int d, input int f);
        return {p[15:0], h[15:0], d[15:0], f[2:0]};
    endfunction

    logic [50:0] exp_got[9];

    initial begin
        rst = 1'b1; x = 1'b0; y = 1'b0; rdy = 1'b1;
        x4 = 1'b0; y4 = 1'b0; rdy4 = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", {valid, per, hi, dly, flg}, '0);
        check("reset_state_w4", {valid4, per4, hi4, dly4, flg4}, '0);

        run_period(10, 4, 3, -1, 1'b1);
        run_period(10, 4, 3, -1, 1'b1);
        run_period(6, 2, 0, -1, 1'b1);
        run_period(6, 2, -1, -1, 1'b1);
        run_period(8, 3, 2, 2, 1'b0);
        run_period(12, 5, 2, -1, 1'b0);
        @(negedge clk);
        check("hold_first", {valid, per}, {1'b1, 16'd8});
        run_period(7, 3, 2, 4, 1'b1);
        run_period(9, 4, 2, 3, 1'b0);
        run_period(11, 5, 1, -1, 1'b0);
        run_period(6, 2, 1, 0, 1'b1);
        check("count_before_reset", got.size(), 8);

        rst = 1'b1; x = 1'b0; y = 1'b0;
        step();
        @(negedge clk);
        check("reset_mid_window", {valid, per, hi, dly, flg}, '0);
        rst = 1'b0;
        run_period(5, 2, 1, -1, 1'b1);
        run_period(5, 2, 1, -1, 1'b1);
        x = 1'b0; y = 1'b0;
        repeat (3) step();

        exp_got[0] = mk(10, 4, 3, 0);
        exp_got[1] = mk(10, 4, 3, 0);
        exp_got[2] = mk(6, 2, 0, 0);
        exp_got[3] = mk(6, 2, MAXC, 2);
        exp_got[4] = mk(8, 3, 2, 0);
        exp_got[5] = mk(7, 3, 2, 4);
        exp_got[6] = mk(9, 4, 2, 0);
        exp_got[7] = mk(11, 5, 1, 0);
        exp_got[8] = mk(5, 2, 1, 0);
        check("transfer_count", got.size(), 9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("transfer_%0d", i), (i < got.size()) ? got[i] : '1, exp_got[i]);
        end

        // Overflow on the 4-bit instance: one X rise, then X held low.
        x4 = 1'b1;
        step();
        x4 = 1'b0;
        repeat (14) step();
        @(negedge clk);
        check("ovf_not_yet", valid4, 1'b0);
        step();
        @(negedge clk);
        check("ovf_valid", valid4, 1'b1);
        check("ovf_result", {per4, hi4, dly4}, {4'd15, 4'd1, 4'd15});
        check("ovf_flag0", flg4[0], 1'b1);
        check("ovf_flags", flg4, 3'b011);
        x4 = 1'b1;
        @(negedge clk);
        check("after_ovf_rise_a", valid4, 1'b0);
        x4 = 1'b0;
        @(negedge clk);
        check("after_ovf_rise_b", valid4, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
